// File: rtl/fft_pingpong_ram.sv
// Ping-pong working memory for an FFT accelerator: the CPU fills one bank
// while the accelerator reads butterfly operand pairs from, and writes results
// into, the other bank. The banks swap when both sides have finished.
module fft_pingpong_ram #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 16,
    localparam int unsigned AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_ready,
    output logic [WIDTH-1:0] cpu_rd_data,
    input  logic             fill_done,
    input  logic             rd_req,
    input  logic [AW-1:0]    rd_addr_a,
    input  logic [AW-1:0]    rd_addr_b,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data_a,
    output logic [WIDTH-1:0] rd_data_b,
    input  logic             acc_we,
    input  logic [AW-1:0]    acc_addr,
    input  logic [WIDTH-1:0] acc_data,
    input  logic             compute_done,
    output logic             compute_active,
    output logic             fill_bank
);

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        STALL = 2'd2
    } state_t;

    state_t state_q;
    state_t state_nxt;
    logic   swap_c;
    logic   fill_bank_nxt;
    logic   wr_ready_nxt;
    logic   compute_active_nxt;

    logic [WIDTH-1:0] mem [2][DEPTH];

    logic wr_in_range_c;
    logic a_in_range_c;
    logic b_in_range_c;
    logic acc_in_range_c;
    logic cmp_bank_c;
    logic cpu_we_c;
    logic acc_we_c;

    // State register; status outputs are registered alongside the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            fill_bank      <= 1'b0;
            wr_ready       <= 1'b1;
            compute_active <= 1'b0;
        end else begin
            state_q        <= state_nxt;
            fill_bank      <= fill_bank_nxt;
            wr_ready       <= wr_ready_nxt;
            compute_active <= compute_active_nxt;
        end
    end

    // Next-state logic; a swap happens whenever a full fill meets a finished compute.
    always_comb begin
        state_nxt = state_q;
        swap_c    = 1'b0;
        case (state_q)
            IDLE: begin
                if (fill_done) begin
                    swap_c    = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (fill_done && compute_done) begin
                    swap_c = 1'b1;
                end else if (compute_done) begin
                    state_nxt = IDLE;
                end else if (fill_done) begin
                    state_nxt = STALL;
                end
            end
            STALL: begin
                if (compute_done) begin
                    swap_c    = 1'b1;
                    state_nxt = BUSY;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered status outputs.
    always_comb begin
        fill_bank_nxt      = fill_bank ^ swap_c;
        wr_ready_nxt       = (state_nxt != STALL);
        compute_active_nxt = (state_nxt != IDLE);
    end

    // Address qualification and write enables for both banks.
    always_comb begin
        wr_in_range_c  = ({1'b0, wr_addr}   < DEPTH_L);
        a_in_range_c   = ({1'b0, rd_addr_a} < DEPTH_L);
        b_in_range_c   = ({1'b0, rd_addr_b} < DEPTH_L);
        acc_in_range_c = ({1'b0, acc_addr}  < DEPTH_L);
        cmp_bank_c     = ~fill_bank;
        cpu_we_c       = wr_en  & wr_ready       & wr_in_range_c;
        acc_we_c       = acc_we & compute_active & acc_in_range_c;
    end

    // Bank storage; CPU and accelerator always target different banks.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < DEPTH; i++) begin
                    mem[b][i] <= '0;
                end
            end
        end else begin
            if (cpu_we_c) begin
                mem[fill_bank][wr_addr] <= wr_data;
            end
            if (acc_we_c) begin
                mem[cmp_bank_c][acc_addr] <= acc_data;
            end
        end
    end

    // Registered read ports; reads see pre-edge contents (read-before-write).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cpu_rd_data <= '0;
            rd_valid    <= 1'b0;
            rd_data_a   <= '0;
            rd_data_b   <= '0;
        end else begin
            cpu_rd_data <= wr_in_range_c ? mem[fill_bank][wr_addr] : '0;
            if (rd_req && compute_active) begin
                rd_valid  <= 1'b1;
                rd_data_a <= a_in_range_c ? mem[cmp_bank_c][rd_addr_a] : '0;
                rd_data_b <= b_in_range_c ? mem[cmp_bank_c][rd_addr_b] : '0;
            end else begin
                rd_valid  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fft_pingpong_ram.sv
// Bench for fft_pingpong_ram: directed scenarios plus random traffic checked
// against a bank/flag model of the ping-pong memory.
module tb_fft_pingpong_ram;

    localparam int D = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [15:0] wr_data;
    logic        wr_ready;
    logic [15:0] cpu_rd_data;
    logic        fill_done;
    logic        rd_req;
    logic [5:0]  rd_addr_a;
    logic [5:0]  rd_addr_b;
    logic        rd_valid;
    logic [15:0] rd_data_a;
    logic [15:0] rd_data_b;
    logic        acc_we;
    logic [5:0]  acc_addr;
    logic [15:0] acc_data;
    logic        compute_done;
    logic        compute_active;
    logic        fill_bank;

    logic        s_wr_en;
    logic [5:0]  s_wr_addr;
    logic [15:0] s_wr_data;
    logic        s_wr_ready;
    logic [15:0] s_cpu_rd_data;
    logic        s_fill_done;
    logic        s_rd_req;
    logic [5:0]  s_rd_addr_a;
    logic [5:0]  s_rd_addr_b;
    logic        s_rd_valid;
    logic [15:0] s_rd_data_a;
    logic [15:0] s_rd_data_b;
    logic        s_compute_active;
    logic        s_fill_bank;

    fft_pingpong_ram #(.DEPTH(64), .WIDTH(16)) u_dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .cpu_rd_data(cpu_rd_data), .fill_done(fill_done),
        .rd_req(rd_req), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_valid(rd_valid), .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .acc_we(acc_we), .acc_addr(acc_addr), .acc_data(acc_data),
        .compute_done(compute_done), .compute_active(compute_active),
        .fill_bank(fill_bank)
    );

    fft_pingpong_ram #(.DEPTH(48), .WIDTH(16)) u_dut48 (
        .clk(clk), .rst(rst),
        .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data), .wr_ready(s_wr_ready),
        .cpu_rd_data(s_cpu_rd_data), .fill_done(s_fill_done),
        .rd_req(s_rd_req), .rd_addr_a(s_rd_addr_a), .rd_addr_b(s_rd_addr_b),
        .rd_valid(s_rd_valid), .rd_data_a(s_rd_data_a), .rd_data_b(s_rd_data_b),
        .acc_we(1'b0), .acc_addr(6'd0), .acc_data(16'd0),
        .compute_done(1'b0), .compute_active(s_compute_active),
        .fill_bank(s_fill_bank)
    );

    // Reference model: two word arrays plus "computing" / "fill finished, waiting" flags.
    logic [15:0] m_bank [2][D];
    int          m_fill;
    bit          m_comp;
    bit          m_wait;
    bit          m_rv;
    logic [15:0] m_ra;
    logic [15:0] m_rb;
    logic [15:0] m_cpu;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < D; i++) m_bank[b][i] = 16'h0;
        m_fill = 0; m_comp = 0; m_wait = 0;
        m_rv = 0; m_ra = 16'h0; m_rb = 16'h0; m_cpu = 16'h0;
    endtask

    task automatic m_step();
        int cb;
        cb = 1 - m_fill;
        m_cpu = m_bank[m_fill][int'(wr_addr)];
        if (rd_req && m_comp) begin
            m_rv = 1;
            m_ra = m_bank[cb][int'(rd_addr_a)];
            m_rb = m_bank[cb][int'(rd_addr_b)];
        end else begin
            m_rv = 0;
        end
        if (wr_en && !m_wait) m_bank[m_fill][int'(wr_addr)] = wr_data;
        if (acc_we && m_comp) m_bank[cb][int'(acc_addr)] = acc_data;
        // A swap needs a finished fill and no compute still running.
        if (!m_comp) begin
            if (fill_done) begin m_fill = cb; m_comp = 1; end
        end else if (!m_wait) begin
            if (fill_done && compute_done) m_fill = cb;
            else if (compute_done) m_comp = 0;
            else if (fill_done) m_wait = 1;
        end else if (compute_done) begin
            m_fill = cb; m_wait = 0;
        end
    endtask

    task automatic check_all();
        chk("wr_ready", 32'(wr_ready), 32'(!(m_comp && m_wait)));
        chk("compute_active", 32'(compute_active), 32'(m_comp));
        chk("fill_bank", 32'(fill_bank), 32'(m_fill));
        chk("rd_valid", 32'(rd_valid), 32'(m_rv));
        chk("rd_data_a", 32'(rd_data_a), 32'(m_ra));
        chk("rd_data_b", 32'(rd_data_b), 32'(m_rb));
        chk("cpu_rd_data", 32'(cpu_rd_data), 32'(m_cpu));
    endtask

    task automatic idle();
        wr_en = 0; fill_done = 0; compute_done = 0; rd_req = 0; acc_we = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        m_step();
        #1;
        check_all();
    endtask

    initial begin
        rst = 0;
        idle();
        wr_addr = 0; wr_data = 0; rd_addr_a = 0; rd_addr_b = 0; acc_addr = 0; acc_data = 0;
        s_wr_en = 0; s_wr_addr = 0; s_wr_data = 0; s_fill_done = 0;
        s_rd_req = 0; s_rd_addr_a = 0; s_rd_addr_b = 0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst = 1;

        // Fill bank0 with its own index, then swap.
        for (int i = 0; i < D; i++) begin
            wr_en = 1; wr_addr = 6'(i); wr_data = 16'(i);
            tick();
        end
        idle();
        fill_done = 1; tick(); idle();
        chk("r036_fill_bank", 32'(fill_bank), 32'd1);
        chk("r036_active", 32'(compute_active), 32'd1);
        rd_req = 1; rd_addr_a = 6'd5; rd_addr_b = 6'd37; tick(); idle();
        chk("r036_valid", 32'(rd_valid), 32'd1);
        chk("r036_a", 32'(rd_data_a), 32'd5);
        chk("r036_b", 32'(rd_data_b), 32'd37);

        // Fill finishes early: stall, dropped write, then swap on compute_done.
        wr_en = 1; wr_addr = 6'd3; wr_data = 16'h0033; tick(); idle();
        fill_done = 1; tick(); idle();
        chk("r037_stall_ready", 32'(wr_ready), 32'd0);
        wr_en = 1; wr_addr = 6'd3; wr_data = 16'hDEAD; tick(); idle();
        fill_done = 1; tick(); idle();
        chk("r037_stall_ignore_fd", 32'(fill_bank), 32'd1);
        compute_done = 1; tick(); idle();
        chk("r037_swap_bank", 32'(fill_bank), 32'd0);
        chk("r037_ready", 32'(wr_ready), 32'd1);
        rd_req = 1; rd_addr_a = 6'd3; rd_addr_b = 6'd4; tick(); idle();
        chk("r037_kept_word", 32'(rd_data_a), 32'h0033);
        chk("r037_unwritten", 32'(rd_data_b), 32'h0);

        // Both done pulses together: single swap, stay busy.
        fill_done = 1; compute_done = 1; tick(); idle();
        chk("r038_bank", 32'(fill_bank), 32'd1);
        chk("r038_active", 32'(compute_active), 32'd1);
        chk("r038_ready", 32'(wr_ready), 32'd1);

        // Accelerator write with same-cycle read of that address.
        acc_we = 1; acc_addr = 6'd10; acc_data = 16'hBEEF;
        rd_req = 1; rd_addr_a = 6'd10; rd_addr_b = 6'd10; tick(); idle();
        chk("r039_old_a", 32'(rd_data_a), 32'd10);
        chk("r039_old_b", 32'(rd_data_b), 32'd10);
        rd_req = 1; rd_addr_a = 6'd10; rd_addr_b = 6'd11; tick(); idle();
        chk("r039_new", 32'(rd_data_a), 32'hBEEF);
        fill_done = 1; compute_done = 1; tick(); idle();
        wr_addr = 6'd10; tick();
        chk("r039_cpu_view", 32'(cpu_rd_data), 32'hBEEF);

        // Back to idle; reads there are ignored.
        compute_done = 1; tick(); idle();
        chk("r040_idle", 32'(compute_active), 32'd0);
        rd_req = 1; rd_addr_a = 6'd1; rd_addr_b = 6'd2; tick(); idle();
        chk("r040_idle_rd", 32'(rd_valid), 32'd0);
        acc_we = 1; acc_addr = 6'd1; acc_data = 16'h7777; tick(); idle();

        // Non power-of-two depth: out-of-range writes dropped, reads give zero.
        s_wr_en = 1; s_wr_addr = 6'd3; s_wr_data = 16'h1234; tick();
        s_wr_addr = 6'd50; s_wr_data = 16'h5555; tick();
        s_wr_en = 0; tick();
        chk("d48_cpu_oob", 32'(s_cpu_rd_data), 32'h0);
        s_fill_done = 1; tick(); s_fill_done = 0;
        chk("d48_active", 32'(s_compute_active), 32'd1);
        s_rd_req = 1; s_rd_addr_a = 6'd50; s_rd_addr_b = 6'd3; tick(); s_rd_req = 0;
        chk("d48_valid", 32'(s_rd_valid), 32'd1);
        chk("d48_rd_oob", 32'(s_rd_data_a), 32'h0);
        chk("d48_rd_ok", 32'(s_rd_data_b), 32'h1234);

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            wr_en        = ($urandom_range(0, 1) == 1);
            wr_addr      = 6'($urandom_range(0, D - 1));
            wr_data      = 16'($urandom);
            rd_req       = ($urandom_range(0, 2) != 0);
            rd_addr_a    = 6'($urandom_range(0, D - 1));
            rd_addr_b    = ($urandom_range(0, 7) == 0) ? rd_addr_a : 6'($urandom_range(0, D - 1));
            acc_we       = ($urandom_range(0, 1) == 1);
            acc_addr     = 6'($urandom_range(0, D - 1));
            acc_data     = 16'($urandom);
            fill_done    = ($urandom_range(0, 9) == 0);
            compute_done = ($urandom_range(0, 9) == 0);
            tick();
        end
        idle();

        // Reach BUSY, then reset mid-compute.
        for (int k = 0; k < 3 && m_comp; k++) begin
            compute_done = 1; tick(); idle();
        end
        fill_done = 1; tick(); idle();
        chk("rst_pre_busy", 32'(compute_active), 32'd1);
        rd_req = 1; rd_addr_a = 6'd0; rd_addr_b = 6'd1; tick(); idle();
        #2;
        rst = 0;
        m_reset();
        #1;
        check_all();
        chk("rst_async_bank", 32'(fill_bank), 32'd0);
        @(negedge clk);
        rst = 1;
        wr_addr = 6'd10; rd_req = 1; rd_addr_a = 6'd0; tick(); idle();
        chk("rst_after_active", 32'(compute_active), 32'd0);
        chk("rst_after_cpu_rd", 32'(cpu_rd_data), 32'h0);
        fill_done = 1; tick(); idle();
        chk("rst_after_swap", 32'(fill_bank), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fft_pingpong_ram.md
FFT_PINGPONG_RAM -- requirements
Module: fft_pingpong_ram

Interface
REQ-001 SHALL have parameter DEPTH, default 64: words per bank (2..1024; any value, not only powers of two).
REQ-002 SHALL have parameter WIDTH, default 16: bits per word.
REQ-003 SHALL have local AW = $clog2(DEPTH).
REQ-004 SHALL have port clk  in  1: clock, rising edge.
REQ-005 SHALL have port rst  in  1: reset, asynchronous, active-low.
REQ-006 SHALL have port wr_en  in  1: CPU write strobe into fill bank.
REQ-007 SHALL have port wr_addr  in  AW: CPU write/read address.
REQ-008 SHALL have port wr_data  in  WIDTH: CPU write data.
REQ-009 SHALL have port wr_ready  out  1: CPU writes accepted.
REQ-010 SHALL have port cpu_rd_data  out  WIDTH: fill-bank word at wr_addr, registered.
REQ-011 SHALL have port fill_done  in  1: one-cycle pulse, fill bank complete.
REQ-012 SHALL have port rd_req  in  1: accelerator dual-read request.
REQ-013 SHALL have port rd_addr_a, rd_addr_b  in  AW each: butterfly operand addresses.
REQ-014 SHALL have port rd_valid  out  1: rd_data_a/b valid.
REQ-015 SHALL have port rd_data_a, rd_data_b  out  WIDTH each: operand data.
REQ-016 SHALL have port acc_we, acc_addr (AW), acc_data (WIDTH)  in: accelerator result write into compute bank.
REQ-017 SHALL have port compute_done  in  1: one-cycle pulse, compute bank finished.
REQ-018 SHALL have ports compute_active  out  1 and fill_bank  out  1: status.

Function
REQ-019 SHALL hold two banks of DEPTH x WIDTH flops; fill bank = fill_bank, compute bank = ~fill_bank.
REQ-020 FSM SHALL have three states: IDLE (no compute), BUSY (compute active, CPU filling), STALL (fill complete, compute active).
REQ-021 IDLE + fill_done -> toggle fill_bank, go BUSY.
REQ-022 BUSY + compute_done only -> IDLE; fill_done only -> STALL; both same cycle -> toggle fill_bank, stay BUSY.
REQ-023 STALL + compute_done -> toggle fill_bank, go BUSY; fill_done in STALL ignored.
REQ-024 wr_ready SHALL be 0 in STALL, else 1; wr_en with wr_ready=0 is dropped.
REQ-025 compute_active SHALL be 1 in BUSY and STALL.
REQ-026 CPU write SHALL update the fill bank at the clock edge; a write in the swap cycle lands in the old fill bank.
REQ-027 cpu_rd_data SHALL be the fill-bank word at wr_addr, one-cycle latency, old data on same-cycle write.
REQ-028 rd_req with compute_active=1 SHALL give rd_valid=1 and both words exactly one cycle later; pipelined every cycle.
REQ-029 rd_req with compute_active=0 SHALL be ignored: rd_valid=0, rd_data_a/b hold.
REQ-030 rd_addr_a == rd_addr_b SHALL return the same word on both outputs.
REQ-031 acc_we SHALL write the compute bank only when compute_active=1; acc_we with same-cycle read of that address returns old data.
REQ-032 Addresses >= DEPTH: writes dropped; reads return 0.
REQ-033 fill_done/compute_done on the cycle of an ignored transition SHALL have no side effect.

Reset
REQ-034 rst low SHALL immediately clear both banks, state IDLE, fill_bank=0, wr_ready=1, rd_valid=0, all data outputs 0.
REQ-035 Reset mid-compute SHALL abort with no swap; first edge after release is normal operation.

Verification
REQ-036 Write 0..63 = i into bank0, fill_done -> fill_bank=1, compute_active=1; rd_req a=5,b=37 -> next cycle rd_valid=1, data 5/37.
REQ-037 BUSY, fill_done -> STALL, wr_ready=0, wr_en to addr 3 dropped; compute_done -> fill_bank toggles, BUSY, wr_ready=1.
REQ-038 fill_done and compute_done same cycle in BUSY -> one toggle, state BUSY.
REQ-039 acc_we addr 10 data 0xBEEF with rd_req a=10 same cycle -> old value read; after compute_done+swap, cpu_rd_data at 10 = 0xBEEF.
REQ-040 rd_req in IDLE -> rd_valid stays 0; DEPTH=48 instance, rd_addr_a=50 -> rd_data_a=0; rst low mid-BUSY -> all outputs 0, IDLE.
